request_queue_p: RTL
====================

# request_queue_p

Parametrised successor to the controller's fixed 16-entry operation queue. Buffers parsed CPU operations (opcode + address) from the parser in FIFO order. Keeps a saturating per-entry age counter and exposes the head entry to the DRAM scheduler through a valid/ripe/pop handshake. Adds occupancy reporting, flow-control flags, sticky overflow/underflow error flags and debug snapshot ports.

## Interface
- DEPTH, 16, number of entries; power of two, ≥2
- ADDRESS_WIDTH, 32, address field width
- AGE_W, 7, age counter width
- MIN_AGE, 100, head becomes ripe when its age ≥ MIN_AGE; must be ≤ 2**AGE_W−1
- PTR_W, $clog2(DEPTH)+1, pointer width (derived, not overridden)

Ports:
- CPU_clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- op_ready_s  in  1  push strobe; opcode_in/address_in valid this cycle
- opcode_in  in  parsed_op_t  opcode to enqueue (global_defs)
- address_in  in  ADDRESS_WIDTH  address to enqueue
- pop  in  1  scheduler consumes head entry
- opcode_out  out  parsed_op_t  head opcode
- address_out  out  ADDRESS_WIDTH  head address
- age_out  out  AGE_W  head age
- head_valid  out  1  queue non-empty
- head_ripe  out  1  head_valid && age_out ≥ MIN_AGE
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  PTR_W  occupancy, 0..DEPTH
- overflow_err  out  1  sticky; push dropped while full
- underflow_err  out  1  sticky; pop while empty
- read_p_out, write_p_out  out  PTR_W  raw pointers (debug)
- address_queue[DEPTH], opcode_queue[DEPTH], counter_queue[DEPTH]  out  per-entry storage snapshot (debug)

## Operation
- Storage is a circular buffer indexed by pointer[PTR_W−2:0]. The pointer MSB is a wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- Push accepted when op_ready_s && (!full || pop). The entry is written at write_p with age 0, and write_p increments modulo 2·DEPTH.
- Push with full && !pop: the entry is dropped, overflow_err is set, and no state changes.
- Pop accepted when pop && !empty: read_p increments and the slot age is cleared.
- Pop while empty: ignored; underflow_err is set.
- Pop does not require head_ripe. The scheduler decides; popping an unripe head is legal.
- Age counting:
  - Each occupied entry increments its age once per cycle.
  - Age saturates at 2**AGE_W−1.
  - Unoccupied slots hold 0.
- Simultaneous push+pop:
  - Non-empty and not full: both occur and count is unchanged.
  - Empty: only the push occurs; underflow_err is set.
  - Full: both occur; no overflow.
- Sticky error flags clear only on reset.
- Head outputs (opcode_out, address_out, age_out) are combinational reads of the read_p slot. They are 0 when empty.
- Reset (asynchronous, any time, including mid-push/pop):
  - Pointers, count, all ages and all storage go to 0.
  - empty=1; full, head_valid, head_ripe and both error flags go to 0.
  - A push or pop in flight at reset assertion is discarded.

## Timing
- Push at edge N: the entry is visible in storage, count and pointers after edge N. If the queue was empty, head_valid=1 in cycle N+1 with age_out=0.
- Age increments at every edge after the push. The head pushed at edge N shows age k in the cycle after edge N+k.
- head_ripe asserts combinationally in the first cycle where age_out ≥ MIN_AGE, i.e. the cycle after edge N+MIN_AGE.
- Pop at edge M: the next entry (with its accumulated age) appears at the head in cycle M+1. There are no bubble cycles.
- The scheduler samples head_* and asserts pop in the same cycle. Push and pop take effect on the same edge.
- full and empty are registered-state derived, so there is no combinational path from op_ready_s or pop to full or empty.
- Throughput is one push and one pop per cycle.

## Test plan
Run with DEPTH=4, MIN_AGE=3, AGE_W=3 unless noted.
- Reset/idle: assert rst_n=0 mid-cycle. Then empty=1, count=0, head_valid=0, and all debug arrays read 0 immediately, without waiting for a clock edge.
- Single op ripening: push READ @0x0000_1000 at edge 1.
  - age_out must step 0,1,2,3 over the following cycles.
  - head_ripe=1 exactly once age_out=3.
  - Pop then returns empty=1 the next cycle.
- Fill and overflow: push 5 ops (0x10, 0x20, 0x30, 0x40, 0x50) on consecutive edges with no pop.
  - count reaches 4 and full=1.
  - 0x50 is dropped and overflow_err=1.
  - Pops return 0x10..0x40 in order.
- Full with concurrent push+pop: from full, push 0x60 and pop on the same edge.
  - count stays 4 and overflow_err stays 0.
  - The head becomes 0x20; 0x60 drains last.
  - write_p wraps through 7→0 correctly.
- Age saturation: hold one entry for 20 cycles. age_out must stick at 7 (2**AGE_W−1) and not wrap to 0.
- Underflow and concurrent ops: pop while empty sets underflow_err=1 with count unchanged. Push+pop on an empty queue yields count=1 with the head holding the pushed op.

Source files
------------

// File: rtl/request_queue_p.sv
// ============================================================================
// Module      : request_queue_p (with package global_defs)
// Description : Parametrised FIFO of parsed CPU operations with per-entry
//               saturating age, ripe/pop head handshake, occupancy, flags,
//               sticky error flags and debug snapshot ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package global_defs;
  typedef enum logic [1:0] {
    NOP     = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    REFRESH = 2'd3
  } parsed_op_t;
endpackage

module request_queue_p
  import global_defs::*;
#(
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = 32,
  parameter int AGE_W         = 7,
  parameter int MIN_AGE       = 100,
  parameter int PTR_W         = $clog2(DEPTH) + 1
) (
  input  logic                     CPU_clk,
  input  logic                     rst_n,
  input  logic                     op_ready_s,
  input  parsed_op_t               opcode_in,
  input  logic [ADDRESS_WIDTH-1:0] address_in,
  input  logic                     pop,
  output parsed_op_t               opcode_out,
  output logic [ADDRESS_WIDTH-1:0] address_out,
  output logic [AGE_W-1:0]         age_out,
  output logic                     head_valid,
  output logic                     head_ripe,
  output logic                     full,
  output logic                     empty,
  output logic [PTR_W-1:0]         count,
  output logic                     overflow_err,
  output logic                     underflow_err,
  output logic [PTR_W-1:0]         read_p_out,
  output logic [PTR_W-1:0]         write_p_out,
  output logic [ADDRESS_WIDTH-1:0] address_queue [DEPTH],
  output parsed_op_t               opcode_queue  [DEPTH],
  output logic [AGE_W-1:0]         counter_queue [DEPTH]
);

  localparam int               c_idx_w   = PTR_W - 1;
  localparam logic [AGE_W-1:0] c_age_max = '1;
  localparam logic [AGE_W-1:0] c_min_age = AGE_W'(MIN_AGE);

  logic [PTR_W-1:0]   r_read_p;
  logic [PTR_W-1:0]   r_write_p;
  logic               r_overflow;
  logic               r_underflow;

  logic [PTR_W-1:0]   w_count;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [c_idx_w-1:0] w_rd_idx;
  logic [c_idx_w-1:0] w_wr_idx;

  // Pointer MSB is a wrap bit, so the difference is the occupancy 0..DEPTH.
  assign w_count  = r_write_p - r_read_p;
  assign w_empty  = (r_read_p == r_write_p);
  assign w_full   = (r_read_p[c_idx_w-1:0] == r_write_p[c_idx_w-1:0]) &&
                    (r_read_p[PTR_W-1] != r_write_p[PTR_W-1]);
  assign w_rd_idx = r_read_p[c_idx_w-1:0];
  assign w_wr_idx = r_write_p[c_idx_w-1:0];

  // When full, a concurrent pop frees the head slot that the push reuses.
  assign w_push = op_ready_s && (!w_full || pop);
  assign w_pop  = pop && !w_empty;

  always_ff @(posedge CPU_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_p    <= '0;
      r_write_p   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_write_p <= r_write_p + 1'b1;
      if (w_pop)  r_read_p  <= r_read_p + 1'b1;
      if (op_ready_s && w_full && !pop) r_overflow <= 1'b1;
      if (pop && w_empty) r_underflow <= 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [ADDRESS_WIDTH-1:0] r_addr;
    parsed_op_t               r_op;
    logic [AGE_W-1:0]         r_age;
    logic [c_idx_w-1:0]       w_rel;
    logic                     w_occ;
    logic                     w_wr;
    logic                     w_rd;

    assign w_rel = c_idx_w'(i) - w_rd_idx;
    assign w_occ = ({1'b0, w_rel} < w_count);
    assign w_wr  = w_push && (w_wr_idx == c_idx_w'(i));
    assign w_rd  = w_pop && (w_rd_idx == c_idx_w'(i));

    always_ff @(posedge CPU_clk or negedge rst_n) begin
      if (!rst_n) begin
        r_addr <= '0;
        r_op   <= NOP;
        r_age  <= '0;
      end else begin
        if (w_wr) begin
          r_addr <= address_in;
          r_op   <= opcode_in;
        end
        if (w_wr || w_rd || !w_occ) begin
          r_age <= '0;
        end else if (r_age != c_age_max) begin
          r_age <= r_age + 1'b1;
        end
      end
    end

    assign address_queue[i] = r_addr;
    assign opcode_queue[i]  = r_op;
    assign counter_queue[i] = r_age;
  end

  assign opcode_out    = w_empty ? NOP : opcode_queue[w_rd_idx];
  assign address_out   = w_empty ? '0 : address_queue[w_rd_idx];
  assign age_out       = w_empty ? '0 : counter_queue[w_rd_idx];
  assign head_valid    = !w_empty;
  assign head_ripe     = !w_empty && (age_out >= c_min_age);
  assign full          = w_full;
  assign empty         = w_empty;
  assign count         = w_count;
  assign overflow_err  = r_overflow;
  assign underflow_err = r_underflow;
  assign read_p_out    = r_read_p;
  assign write_p_out   = r_write_p;

endmodule

`default_nettype wire
